// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM states and character constants for the Morse character assembler.
package morse_pkg;

    typedef enum logic [1:0] {
        SYM_NONE = 2'b00,
        SYM_DOT  = 2'b01,
        SYM_DASH = 2'b10,
        SYM_GAP  = 2'b11
    } sym_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_GAP     = 2'b10
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_UNK   = 8'h3F;
    localparam int         LEN_W       = 3;
    localparam int         PAT_W       = 5;
    localparam logic [LEN_W-1:0] MAX_LEN = 3'd5;

    // Newest element enters at bit0, so the first element of a letter ends up as the MSB of len bits.
    function automatic logic [PAT_W-1:0] shift_elem(input logic [PAT_W-1:0] pat,
                                                    input logic             is_dash);
        return {pat[PAT_W-2:0], is_dash};
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational decode of an assembled Morse pattern (length + element bits) to ASCII A-Z / 0-9.
module morse_lut
    import morse_pkg::*;
(
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit,
    output logic [7:0]       ascii
);

    // Key is {len, pattern}; dot = 0, dash = 1, first element in the highest used bit.
    always_comb begin
        hit   = 1'b1;
        ascii = ASCII_UNK;
        case ({len, pattern})
            {3'd1, 5'b00000}: ascii = "E";
            {3'd1, 5'b00001}: ascii = "T";
            {3'd2, 5'b00001}: ascii = "A";
            {3'd2, 5'b00000}: ascii = "I";
            {3'd2, 5'b00011}: ascii = "M";
            {3'd2, 5'b00010}: ascii = "N";
            {3'd3, 5'b00100}: ascii = "D";
            {3'd3, 5'b00110}: ascii = "G";
            {3'd3, 5'b00101}: ascii = "K";
            {3'd3, 5'b00111}: ascii = "O";
            {3'd3, 5'b00010}: ascii = "R";
            {3'd3, 5'b00000}: ascii = "S";
            {3'd3, 5'b00001}: ascii = "U";
            {3'd3, 5'b00011}: ascii = "W";
            {3'd4, 5'b01000}: ascii = "B";
            {3'd4, 5'b01010}: ascii = "C";
            {3'd4, 5'b00010}: ascii = "F";
            {3'd4, 5'b00000}: ascii = "H";
            {3'd4, 5'b00111}: ascii = "J";
            {3'd4, 5'b00100}: ascii = "L";
            {3'd4, 5'b00110}: ascii = "P";
            {3'd4, 5'b01101}: ascii = "Q";
            {3'd4, 5'b00001}: ascii = "V";
            {3'd4, 5'b01001}: ascii = "X";
            {3'd4, 5'b01011}: ascii = "Y";
            {3'd4, 5'b01100}: ascii = "Z";
            {3'd5, 5'b11111}: ascii = "0";
            {3'd5, 5'b01111}: ascii = "1";
            {3'd5, 5'b00111}: ascii = "2";
            {3'd5, 5'b00011}: ascii = "3";
            {3'd5, 5'b00001}: ascii = "4";
            {3'd5, 5'b00000}: ascii = "5";
            {3'd5, 5'b10000}: ascii = "6";
            {3'd5, 5'b11000}: ascii = "7";
            {3'd5, 5'b11100}: ascii = "8";
            {3'd5, 5'b11110}: ascii = "9";
            default: begin
                hit   = 1'b0;
                ascii = ASCII_UNK;
            end
        endcase
    end

endmodule

// File: rtl/morse_char_assembler.sv
// Assembles dot/dash/gap symbol strobes into ASCII characters on a valid/ready stream,
// with word-gap spaces, an idle auto-flush and overflow/drop error pulses.
module morse_char_assembler
    import morse_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 1023,
    parameter int CNT_W        = 16,
    parameter int EMIT_SPACE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       err_ovf,
    output logic       err_drop
);

    localparam bit             TO_EN   = (IDLE_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TO_EN ? IDLE_TIMEOUT : 0);

    // Idle counter saturates so it never wraps back into a spurious expiry.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == TO_MAX) ? c : c + CNT_W'(1);
    endfunction

    state_e           state, state_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic [PAT_W-1:0] pattern, pat_nxt;
    logic             ovf, ovf_nxt;
    logic [CNT_W-1:0] idle_cnt;

    logic             sym_act, sym_elem, sym_gap, elem_bit;
    logic             to_fire;
    logic             ovf_hit;
    logic             emit;
    logic [7:0]       emit_char;
    logic             lut_hit;
    logic [7:0]       lut_ascii;

    assign sym_act  = sym_valid && (sym_in != SYM_NONE);
    assign sym_elem = sym_act && ((sym_in == SYM_DOT) || (sym_in == SYM_DASH));
    assign sym_gap  = sym_act && (sym_in == SYM_GAP);
    assign elem_bit = (sym_in == SYM_DASH);

    // A symbol arriving in the expiry cycle takes priority over the timeout.
    assign to_fire = TO_EN && !sym_act && (idle_cnt == TO_LAST)
                     && ((state == S_COLLECT) || (state == S_GAP));

    morse_lut u_lut (
        .len     (len),
        .pattern (pattern),
        .hit     (lut_hit),
        .ascii   (lut_ascii)
    );

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        pat_nxt   = pattern;
        ovf_nxt   = ovf;
        ovf_hit   = 1'b0;
        emit      = 1'b0;
        emit_char = ASCII_UNK;
        case (state)
            S_IDLE: begin
                if (sym_elem) begin
                    len_nxt   = 3'd1;
                    pat_nxt   = {{(PAT_W-1){1'b0}}, elem_bit};
                    ovf_nxt   = 1'b0;
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (sym_elem) begin
                    if (len < MAX_LEN) begin
                        len_nxt = len + 3'd1;
                        pat_nxt = shift_elem(pattern, elem_bit);
                    end else begin
                        ovf_nxt = 1'b1;
                        ovf_hit = !ovf;
                    end
                end else if (sym_gap || to_fire) begin
                    emit      = 1'b1;
                    emit_char = (ovf || !lut_hit) ? ASCII_UNK : lut_ascii;
                    len_nxt   = '0;
                    pat_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (sym_elem) begin
                    len_nxt   = 3'd1;
                    pat_nxt   = {{(PAT_W-1){1'b0}}, elem_bit};
                    ovf_nxt   = 1'b0;
                    state_nxt = S_COLLECT;
                end else if (sym_gap) begin
                    emit      = (EMIT_SPACE != 0);
                    emit_char = ASCII_SPACE;
                    state_nxt = S_IDLE;
                end else if (to_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: letter state, idle counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= '0;
            pattern  <= '0;
            ovf      <= 1'b0;
            idle_cnt <= '0;
            err_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            pattern  <= pat_nxt;
            ovf      <= ovf_nxt;
            idle_cnt <= (sym_act || to_fire) ? '0 : sat_inc(idle_cnt);
            err_ovf  <= ovf_hit;
        end
    end

    // Stage p1: output holding register; a stalled output keeps its char and drops the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_out   <= '0;
            char_valid <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            err_drop <= 1'b0;
            if (emit && char_valid && !char_ready) begin
                err_drop <= 1'b1;
            end else if (emit) begin
                char_out   <= emit_char;
                char_valid <= 1'b1;
            end else if (char_valid && char_ready) begin
                char_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_char_assembler.sv
// Directed scoreboard bench for morse_char_assembler: default, no-space and short-timeout instances.
module tb_morse_char_assembler;

    localparam logic [1:0] DOT  = 2'b01;
    localparam logic [1:0] DASH = 2'b10;
    localparam logic [1:0] GAP  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sym   [3];
    logic       sv    [3];
    logic       rdy   [3];
    logic [7:0] cout  [3];
    logic       cval  [3];
    logic       eovf  [3];
    logic       edrop [3];

    int checks = 0;
    int errors = 0;
    int k;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    morse_char_assembler u_main (
        .clk(clk), .rst(rst), .sym_in(sym[0]), .sym_valid(sv[0]),
        .char_out(cout[0]), .char_valid(cval[0]), .char_ready(rdy[0]),
        .err_ovf(eovf[0]), .err_drop(edrop[0])
    );

    morse_char_assembler #(.EMIT_SPACE(0)) u_nosp (
        .clk(clk), .rst(rst), .sym_in(sym[1]), .sym_valid(sv[1]),
        .char_out(cout[1]), .char_valid(cval[1]), .char_ready(rdy[1]),
        .err_ovf(eovf[1]), .err_drop(edrop[1])
    );

    morse_char_assembler #(.IDLE_TIMEOUT(8)) u_to (
        .clk(clk), .rst(rst), .sym_in(sym[2]), .sym_valid(sv[2]),
        .char_out(cout[2]), .char_valid(cval[2]), .char_ready(rdy[2]),
        .err_ovf(eovf[2]), .err_drop(edrop[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input int d, input logic [7:0] got);
        int n;
        logic [7:0] e;
        n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            assert (n != 0) else begin
                errors++;
                $error("FAIL sb%0d_unexpected observed=%0h expected=none", d, got);
            end
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("sb%0d_char", d), {24'h0, got}, {24'h0, e});
        end
    endtask

    // Inputs change at negedge+1; the monitor looks at negedge+2, i.e. the values the next posedge uses.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (cval[d] && rdy[d]) sb_pop(d, cout[d]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [1:0] s);
        sym[d] = s;
        sv[d]  = 1'b1;
        step();
        sv[d]  = 1'b0;
        sym[d] = 2'b00;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            sym[d] = 2'b00;
            sv[d]  = 1'b0;
            rdy[d] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) step();
        chk("rst_char_out", cout[0], 8'h00);
        chk("rst_char_valid", cval[0], 1'b0);
        chk("rst_err_ovf", eovf[0], 1'b0);
        chk("rst_err_drop", edrop[0], 1'b0);
        chk("rst_nosp_valid", cval[1], 1'b0);
        chk("rst_to_valid", cval[2], 1'b0);
        rst = 1'b0;
        step();

        // 'A' with one-cycle latency and a single valid cycle
        send(0, DOT);
        send(0, DASH);
        q0.push_back(8'h41);
        send(0, GAP);
        chk("a_valid_latency", cval[0], 1'b1);
        chk("a_char", cout[0], 8'h41);
        step();
        chk("a_valid_one_cycle", cval[0], 1'b0);

        // '0' then 'H'
        repeat (5) send(0, DASH);
        q0.push_back(8'h30);
        send(0, GAP);
        repeat (4) send(0, DOT);
        q0.push_back(8'h48);
        send(0, GAP);
        chk("h_char", cout[0], 8'h48);
        step();

        // six dots overflow into '?'
        repeat (5) send(0, DOT);
        chk("ovf_quiet_at_5", eovf[0], 1'b0);
        send(0, DOT);
        chk("ovf_pulse", eovf[0], 1'b1);
        step();
        chk("ovf_pulse_clear", eovf[0], 1'b0);
        q0.push_back(8'h3F);
        send(0, GAP);
        chk("ovf_char", cout[0], 8'h3F);
        q0.push_back(8'h20);
        send(0, GAP);
        chk("ovf_then_space", cout[0], 8'h20);
        step();

        // 'E' followed by a word gap
        send(0, DOT);
        q0.push_back(8'h45);
        send(0, GAP);
        q0.push_back(8'h20);
        send(0, GAP);
        chk("e_space_valid", cval[0], 1'b1);
        chk("e_space_char", cout[0], 8'h20);
        step();
        step();

        // same on the instance with spaces suppressed
        send(1, DOT);
        q1.push_back(8'h45);
        send(1, GAP);
        chk("nosp_e_char", cout[1], 8'h45);
        send(1, GAP);
        chk("nosp_no_space", cval[1], 1'b0);
        repeat (3) step();

        // stalled output: 'T' held, 'E' dropped
        rdy[0] = 1'b0;
        send(0, DASH);
        q0.push_back(8'h54);
        send(0, GAP);
        chk("stall_t_valid", cval[0], 1'b1);
        chk("stall_t_char", cout[0], 8'h54);
        step();
        chk("stall_t_held", cval[0], 1'b1);
        send(0, DOT);
        send(0, GAP);
        chk("stall_drop_pulse", edrop[0], 1'b1);
        chk("stall_char_kept", cout[0], 8'h54);
        step();
        chk("stall_drop_clear", edrop[0], 1'b0);
        chk("stall_char_still", cout[0], 8'h54);
        // accept 'T' in the same cycle a space is emitted
        rdy[0] = 1'b1;
        q0.push_back(8'h20);
        send(0, GAP);
        chk("accept_emit_valid", cval[0], 1'b1);
        chk("accept_emit_char", cout[0], 8'h20);
        step();
        chk("accept_emit_done", cval[0], 1'b0);

        // reset mid-handshake and mid-letter
        rdy[0] = 1'b0;
        send(0, DASH);
        send(0, GAP);
        chk("rst_hs_pending", cval[0], 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_hs_dropped", cval[0], 1'b0);
        rdy[0] = 1'b1;
        send(0, DOT);
        send(0, DASH);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_letter_none", cval[0], 1'b0);
        send(0, DASH);
        q0.push_back(8'h54);
        send(0, GAP);
        chk("rst_then_t", cout[0], 8'h54);
        step();

        // idle auto-flush after 8 cycles, no space afterwards
        send(2, DOT);
        q2.push_back(8'h41);
        send(2, DASH);
        k = 0;
        while (!cval[2] && k < 20) begin
            step();
            k++;
        end
        chk("timeout_latency", k, 8);
        chk("timeout_char", cout[2], 8'h41);
        repeat (30) step();
        chk("timeout_no_space", cval[2], 1'b0);

        // symbol arriving in the expiry cycle wins
        send(2, DOT);
        repeat (7) step();
        send(2, DASH);
        chk("timeout_sym_wins", cval[2], 1'b0);
        q2.push_back(8'h41);
        send(2, GAP);
        chk("timeout_sym_char", cout[2], 8'h41);
        repeat (30) step();

        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        chk("sb2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
